// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: two valid/ready writeback requesters plus the regfile write/read ports.
// slave = arbiter side, master = requester/regfile side.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              REQ0_VALID;
  logic              REQ0_READY;
  logic [ADDR_W-1:0] REQ0_ADDR;
  logic [DATA_W-1:0] REQ0_DATA;
  logic              REQ0_LAST;
  logic              REQ1_VALID;
  logic              REQ1_READY;
  logic [ADDR_W-1:0] REQ1_ADDR;
  logic [DATA_W-1:0] REQ1_DATA;
  logic              REQ1_LAST;
  logic              W_EN;
  logic [ADDR_W-1:0] RADDR3_W;
  logic [DATA_W-1:0] WDATA;
  logic [ADDR_W-1:0] RADDR1_R;
  logic [ADDR_W-1:0] RADDR2_R;
  logic [DATA_W-1:0] RF_RDATA1;
  logic [DATA_W-1:0] RF_RDATA2;
  logic [DATA_W-1:0] RDATA1;
  logic [DATA_W-1:0] RDATA2;

  modport slave (
    input  REQ0_VALID, REQ0_ADDR, REQ0_DATA, REQ0_LAST,
    input  REQ1_VALID, REQ1_ADDR, REQ1_DATA, REQ1_LAST,
    input  RADDR1_R, RADDR2_R, RF_RDATA1, RF_RDATA2,
    output REQ0_READY, REQ1_READY, W_EN, RADDR3_W, WDATA, RDATA1, RDATA2
  );

  modport master (
    output REQ0_VALID, REQ0_ADDR, REQ0_DATA, REQ0_LAST,
    output REQ1_VALID, REQ1_ADDR, REQ1_DATA, REQ1_LAST,
    output RADDR1_R, RADDR2_R, RF_RDATA1, RF_RDATA2,
    input  REQ0_READY, REQ1_READY, W_EN, RADDR3_W, WDATA, RDATA1, RDATA2
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing the regfile write port; handshake -> W_EN in 1 cycle,
// non-granted requesters see READY=0 and must hold. `define WB_BYPASS_EN forwards the in-flight write to readers.
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int RESET_PTR = 0
) (
  input  logic               CLK,
  input  logic               RST,
  wb_port_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;
  localparam logic       PTR_RST  = (RESET_PTR != 0);

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt0, gnt1;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    ptr_d   = ptr_q;
    w_en_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ0_VALID && bus.REQ1_VALID) begin
          gnt0 = !ptr_q;
          gnt1 = ptr_q;
        end else begin
          gnt0 = bus.REQ0_VALID;
          gnt1 = bus.REQ1_VALID;
        end
      end
      ST_LOCK0: gnt0 = bus.REQ0_VALID;
      ST_LOCK1: gnt1 = bus.REQ1_VALID;
      default:  state_d = ST_IDLE;
    endcase

    // READY must stay low for the whole time reset is asserted, not just after the next edge.
    if (!RST) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      ptr_d   = 1'b1;
      state_d = bus.REQ0_LAST ? ST_IDLE : ST_LOCK0;
      w_en_d  = 1'b1;
      waddr_d = bus.REQ0_ADDR;
      wdata_d = bus.REQ0_DATA;
    end else if (gnt1) begin
      ptr_d   = 1'b0;
      state_d = bus.REQ1_LAST ? ST_IDLE : ST_LOCK1;
      w_en_d  = 1'b1;
      waddr_d = bus.REQ1_ADDR;
      wdata_d = bus.REQ1_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign bus.W_EN       = w_en_q;
  assign bus.RADDR3_W   = waddr_q;
  assign bus.WDATA      = wdata_q;

`ifdef WB_BYPASS_EN
  assign bus.RDATA1 = (w_en_q && (waddr_q == bus.RADDR1_R)) ? wdata_q : bus.RF_RDATA1;
  assign bus.RDATA2 = (w_en_q && (waddr_q == bus.RADDR2_R)) ? wdata_q : bus.RF_RDATA2;
`else
  logic unused_bypass;
  assign unused_bypass = ^{bus.RADDR1_R, bus.RADDR2_R};
  assign bus.RDATA1    = bus.RF_RDATA1;
  assign bus.RDATA2    = bus.RF_RDATA2;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback, requester 1 is load/LDM writeback. Each requester uses a valid/ready handshake. Round-robin arbitration with burst lock keeps multi-register loads contiguous. Drives the REGFILE write-port signals W_EN, RADDR3_W and WDATA through a one-stage output register.

Parameters:
DATA_W, 32, data width of the write port
ADDR_W, 4, register address width (16 registers)
RESET_PTR, 0, requester holding round-robin priority after reset

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
REQ0_VALID  input  1  requester 0 has a write pending
REQ0_READY  output  1  requester 0 granted this cycle
REQ0_ADDR  input  ADDR_W  requester 0 destination register
REQ0_DATA  input  DATA_W  requester 0 write data
REQ0_LAST  input  1  requester 0 final beat of burst (tie 1 if unused)
REQ1_VALID  input  1  requester 1 write pending
REQ1_READY  output  1  requester 1 granted this cycle
REQ1_ADDR  input  ADDR_W  requester 1 destination register
REQ1_DATA  input  DATA_W  requester 1 write data
REQ1_LAST  input  1  requester 1 final beat of burst
W_EN  output  1  regfile write enable (registered)
RADDR3_W  output  ADDR_W  regfile write address (registered)
WDATA  output  DATA_W  regfile write data (registered)
RADDR1_R  input  ADDR_W  regfile read address 1 (observed for bypass)
RADDR2_R  input  ADDR_W  regfile read address 2
RF_RDATA1  input  DATA_W  regfile RDATA1
RF_RDATA2  input  DATA_W  regfile RDATA2
RDATA1  output  DATA_W  read data 1 to datapath
RDATA2  output  DATA_W  read data 2 to datapath

Behaviour:
- Reset (RST=0, asynchronous):
  - State=IDLE, ptr=RESET_PTR.
  - W_EN=0, RADDR3_W=0, WDATA=0.
  - READY outputs are low while RST=0.
- States: IDLE, LOCK0, LOCK1.
- Grant logic is combinational from state, ptr and VALIDs. READY is never asserted to a non-valid requester.
- IDLE grant rules:
  - Only one valid: that requester is granted.
  - Both valid: requester ptr is granted.
  - Neither valid: no grant.
- LOCKn grant rules:
  - Only requester n may be granted, and only when REQn_VALID=1.
  - The other requester gets READY=0 even if requester n is idle.
- Transfer occurs when REQn_VALID & REQn_READY.
- On a transfer by requester n:
  - ptr <= ~n.
  - LAST=0: state <= LOCKn.
  - LAST=1: state <= IDLE.
- In LOCKn with no transfer, state holds. There is no timeout.
- Output stage, on every rising CLK:
  - W_EN <= transfer occurred.
  - On a transfer: RADDR3_W <= granted ADDR, WDATA <= granted DATA.
  - With no transfer: RADDR3_W and WDATA hold their previous values.
- Latency: exactly 1 cycle from handshake to W_EN. Throughput is 1 write per cycle; back-to-back grants are allowed.
- Same-address writes in consecutive cycles are written in grant order; the last one wins in the regfile.
- Both requesters asserting LAST=0 simultaneously in IDLE: only the granted requester locks.
- Reset mid-burst aborts the lock and drops any pending output write (W_EN=0 immediately).
- Without the bypass feature, RDATA1=RF_RDATA1 and RDATA2=RF_RDATA2.

Optional Feature:
WB_BYPASS_EN:
- Defined: RDATA1 = (W_EN && RADDR3_W==RADDR1_R) ? WDATA : RF_RDATA1. RDATA2 follows the same rule. This forwards the in-flight write to same-cycle readers. Purely combinational; adds no latency.
- Undefined: RDATA1/RDATA2 pass RF_RDATA1/RF_RDATA2 straight through. Bypass ports remain, unused.

Test Plan:
1. Reset, then REQ0 VALID addr=3 data=32'd7 LAST=1 alone -> REQ0_READY=1 same cycle. Next cycle W_EN=1, RADDR3_W=3, WDATA=7. Following cycle W_EN=0.
2. Both valid for 4 cycles (REQ0 addr=1 data=10, REQ1 addr=2 data=20, LAST=1), RESET_PTR=0 -> grants alternate 0,1,0,1. W_EN=1 for 4 consecutive cycles with RADDR3_W 1,2,1,2.
3. REQ1 burst addr 4,5,6 with LAST=0,0,1 while REQ0 continuously valid -> REQ0_READY=0 throughout the burst. Writes 4,5,6 occur contiguously, then REQ0 is granted on the next cycle.
4. In LOCK1, drop REQ1_VALID for 2 cycles with REQ0 valid -> no grants and W_EN=0 for those cycles. Burst resumes when REQ1_VALID returns.
5. Assert RST=0 mid-burst, between edges -> W_EN falls immediately and state returns to IDLE. After release, REQ0 is granted at once.
6. WB_BYPASS_EN defined: write addr=9 data=32'hDEAD, RADDR1_R=9, RF_RDATA1=0 in the W_EN cycle -> RDATA1=32'hDEAD. Undefined: RDATA1=0.
